// File: rtl/sevenseg4dcapture.sv
// Captures a multiplexed, active-low 4-digit seven-segment display into per-digit registers.
// Inputs are synchronized, debounced by a stability counter, then decoded to hex.
module sevenseg4dcapture #(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  segments,
  input  logic [3:0]  anodes,
  output logic [6:0]  digit0_segments,
  output logic [6:0]  digit1_segments,
  output logic [6:0]  digit2_segments,
  output logic [6:0]  digit3_segments,
  output logic [15:0] digit_hex,
  output logic [3:0]  hex_valid,
  output logic        capture_valid,
  output logic [1:0]  capture_idx,
  output logic        frame_done,
  output logic        anode_error
);

  localparam logic [7:0] SettleMax  = 8'(SETTLE_CYCLES);
  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  // Bits [10:7] hold anodes, [6:0] hold segments (both still active-low).
  logic [10:0] s1_q, s2_q, p_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        stable, capture;

  logic [3:0][6:0] digit_q, digit_d;
  logic [3:0][3:0] nib_q, nib_d;
  logic [3:0]      hv_q, hv_d;
  logic [3:0]      seen_q, seen_d, seen_upd;
  logic            cv_q, cv_d;
  logic [1:0]      idx_q, idx_d;
  logic            fd_q, fd_d;
  logic            err_q, err_d;

  logic [1:0] sel_idx;
  logic       sel_one, sel_multi;
  logic [6:0] pattern;
  logic [3:0] dec_nib;
  logic       dec_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q  <= '1;
      s2_q  <= '1;
      p_q   <= '1;
      cnt_q <= '0;
    end else begin
      s1_q  <= {anodes, segments};
      s2_q  <= s1_q;
      p_q   <= s2_q;
      cnt_q <= cnt_d;
    end
  end

  assign stable  = (s2_q == p_q);
  assign capture = stable && (cnt_q == SettleLast);

  always_comb begin
    cnt_d = cnt_q;
    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q != SettleMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    sel_idx   = 2'd0;
    sel_one   = 1'b0;
    sel_multi = 1'b0;
    unique case (s2_q[10:7])
      4'b1110: begin sel_one = 1'b1; sel_idx = 2'd0; end
      4'b1101: begin sel_one = 1'b1; sel_idx = 2'd1; end
      4'b1011: begin sel_one = 1'b1; sel_idx = 2'd2; end
      4'b0111: begin sel_one = 1'b1; sel_idx = 2'd3; end
      4'b1111: begin sel_one = 1'b0; end
      default: begin sel_multi = 1'b1; end
    endcase
  end

  assign pattern = ~s2_q[6:0];

  always_comb begin
    dec_nib = 4'h0;
    dec_ok  = 1'b1;
    case (pattern)
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'h0;
        dec_ok  = 1'b0;
      end
    endcase
  end

  assign seen_upd = seen_q | (4'b0001 << sel_idx);

  always_comb begin
    digit_d = digit_q;
    nib_d   = nib_q;
    hv_d    = hv_q;
    seen_d  = seen_q;
    err_d   = err_q;
    idx_d   = idx_q;
    cv_d    = 1'b0;
    fd_d    = 1'b0;
    if (capture) begin
      if (sel_one) begin
        digit_d[sel_idx] = pattern;
        nib_d[sel_idx]   = dec_nib;
        hv_d[sel_idx]    = dec_ok;
        cv_d             = 1'b1;
        idx_d            = sel_idx;
        // Completing the mask ends the frame and starts a new one immediately.
        if (seen_upd == 4'b1111) begin
          fd_d   = 1'b1;
          seen_d = 4'b0000;
        end else begin
          seen_d = seen_upd;
        end
      end else if (sel_multi) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q <= '0;
      nib_q   <= '0;
      hv_q    <= '0;
      seen_q  <= '0;
      cv_q    <= 1'b0;
      idx_q   <= 2'd0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      digit_q <= digit_d;
      nib_q   <= nib_d;
      hv_q    <= hv_d;
      seen_q  <= seen_d;
      cv_q    <= cv_d;
      idx_q   <= idx_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign digit0_segments = digit_q[0];
  assign digit1_segments = digit_q[1];
  assign digit2_segments = digit_q[2];
  assign digit3_segments = digit_q[3];
  assign digit_hex       = nib_q;
  assign hex_valid       = hv_q;
  assign capture_valid   = cv_q;
  assign capture_idx     = idx_q;
  assign frame_done      = fd_q;
  assign anode_error     = err_q;

endmodule

// File: tb/tb_sevenseg4dcapture.sv
// Bench for sevenseg4dcapture: vector table, hand-written timing sequences and random traffic
// checked every cycle against a history-window reference model.
module tb_sevenseg4dcapture;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  segments = 7'h7F;
  logic [3:0]  anodes = 4'hF;
  logic [6:0]  digit0_segments, digit1_segments, digit2_segments, digit3_segments;
  logic [15:0] digit_hex;
  logic [3:0]  hex_valid;
  logic        capture_valid;
  logic [1:0]  capture_idx;
  logic        frame_done;
  logic        anode_error;

  sevenseg4dcapture #(.SETTLE_CYCLES(S)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .segments        (segments),
    .anodes          (anodes),
    .digit0_segments (digit0_segments),
    .digit1_segments (digit1_segments),
    .digit2_segments (digit2_segments),
    .digit3_segments (digit3_segments),
    .digit_hex       (digit_hex),
    .hex_valid       (hex_valid),
    .capture_valid   (capture_valid),
    .capture_idx     (capture_idx),
    .frame_done      (frame_done),
    .anode_error     (anode_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a capture happens when the last S+1 synchronized samples agree and the
  // sample before that window differs (or the window reaches back to the reset point).
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [10:0] pipe_s1, pipe_s2;
  logic [10:0] dq[$];
  bit          armed = 0;
  logic [6:0]  m_dig [4];
  logic [3:0]  m_nib [4];
  logic [3:0]  m_hv, m_seen;
  logic        m_cv, m_fd, m_err;
  logic [1:0]  m_idx;

  always @(posedge clk) begin
    logic [10:0] d;
    logic [3:0]  an;
    bit          cap;
    int          sz, n;
    if (!rst_n) begin
      armed = 1;
      pipe_s1 = '1;
      pipe_s2 = '1;
      dq.delete();
      dq.push_back(11'h7FF);
      for (int i = 0; i < 4; i++) begin
        m_dig[i] = '0;
        m_nib[i] = '0;
      end
      m_hv = '0; m_seen = '0; m_cv = 0; m_fd = 0; m_err = 0; m_idx = '0;
    end else if (armed) begin
      m_cv = 0;
      m_fd = 0;
      d = pipe_s2;
      dq.push_back(d);
      if (dq.size() > S + 2) void'(dq.pop_front());
      sz = dq.size();
      cap = (sz >= S + 1);
      if (cap) begin
        for (int i = sz - S - 1; i < sz; i++) if (dq[i] != d) cap = 0;
        if (sz > S + 1 && dq[sz-S-2] == d) cap = 0;
      end
      if (cap) begin
        an = d[10:7];
        if ($countones(~an) == 1) begin
          n = 0;
          for (int i = 0; i < 4; i++) if (!an[i]) n = i;
          m_dig[n] = ~d[6:0];
          m_nib[n] = 4'h0;
          m_hv[n]  = 1'b0;
          for (int g = 0; g < 16; g++) begin
            if (glyph[g] == ~d[6:0]) begin
              m_nib[n] = 4'(g);
              m_hv[n]  = 1'b1;
            end
          end
          m_cv = 1;
          m_idx = 2'(n);
          m_seen[n] = 1'b1;
          if (m_seen == 4'hF) begin
            m_fd = 1;
            m_seen = '0;
          end
        end else if ($countones(~an) >= 2) begin
          m_err = 1;
        end
      end
      pipe_s2 = pipe_s1;
      pipe_s1 = {anodes, segments};
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model",
          {11'd0, digit0_segments, digit1_segments, digit2_segments, digit3_segments, digit_hex,
           hex_valid, capture_valid, capture_idx, frame_done, anode_error},
          {11'd0, m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_nib[3], m_nib[2], m_nib[1], m_nib[0],
           m_hv, m_cv, m_idx, m_fd, m_err});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] pat);
    anodes   = an;
    segments = ~pat;
  endtask

  task automatic hold(input int n, inout int p, inout int f);
    repeat (n) begin
      @(negedge clk);
      p += int'(capture_valid);
      f += int'(frame_done);
    end
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  pat;
    int          cycles;
    int          pulses;
    int          frames;
    logic [15:0] hex;
    logic [3:0]  hv;
    logic        err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int p, f;
    tbl[0] = '{4'b1110, 7'h3F, 20, 1, 0, 16'h0000, 4'b0001, 1'b0};
    tbl[1] = '{4'b1101, 7'h5B, 20, 1, 0, 16'h0020, 4'b0011, 1'b0};
    tbl[2] = '{4'b1011, 7'h4F, 20, 1, 0, 16'h0320, 4'b0111, 1'b0};
    tbl[3] = '{4'b0111, 7'h66, 20, 1, 1, 16'h4320, 4'b1111, 1'b0};
    tbl[4] = '{4'b1101, 7'h49, 20, 1, 0, 16'h4300, 4'b1101, 1'b0};
    tbl[5] = '{4'b1111, 7'h00, 20, 0, 0, 16'h4300, 4'b1101, 1'b0};
    tbl[6] = '{4'b1100, 7'h3F, 20, 0, 0, 16'h4300, 4'b1101, 1'b1};
    tbl[7] = '{4'b1110, 7'h06, 20, 1, 0, 16'h4301, 4'b1101, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_state",
        {digit0_segments, digit1_segments, digit2_segments, digit3_segments, digit_hex,
         hex_valid, capture_valid, capture_idx, frame_done, anode_error}, '0);

    // First-capture latency: input set before edge 1 appears after edge S+3
    rst_n = 1'b1;
    drive(4'b1110, 7'h06);
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == S + 3) begin
        chk("lat_cv", capture_valid, 1);
        chk("lat_seg", digit0_segments, 7'h06);
        chk("lat_hex", digit_hex[3:0], 4'h1);
        chk("lat_hv", hex_valid[0], 1);
        chk("lat_idx", capture_idx, 0);
      end else begin
        chk("lat_nocv", capture_valid, 0);
      end
    end
    p = 0; f = 0;
    hold(12, p, f);
    chk("lat_single", p, 0);

    for (int i = 0; i < 8; i++) begin
      p = 0; f = 0;
      drive(tbl[i].an, tbl[i].pat);
      hold(tbl[i].cycles, p, f);
      chk($sformatf("tbl%0d_pulses", i), p, tbl[i].pulses);
      chk($sformatf("tbl%0d_frames", i), f, tbl[i].frames);
      chk($sformatf("tbl%0d_hex", i), digit_hex, tbl[i].hex);
      chk($sformatf("tbl%0d_hv", i), hex_valid, tbl[i].hv);
      chk($sformatf("tbl%0d_err", i), anode_error, tbl[i].err);
    end
    chk("tbl_d1_seg", digit1_segments, 7'h49);

    // Blank glitch inside a held digit
    p = 0; f = 0;
    drive(4'b1011, 7'h7F);
    hold(20, p, f);
    chk("glitch_pre", p, 1);
    p = 0;
    drive(4'b1111, 7'h00);
    hold(2, p, f);
    chk("glitch_during", p, 0);
    drive(4'b1011, 7'h7F);
    hold(20, p, f);
    chk("glitch_after", p, 1);
    chk("glitch_d2", digit2_segments, 7'h7F);

    // Stability boundary: S samples do not capture, S+1 do
    p = 0; f = 0;
    drive(4'b1111, 7'h00);
    hold(10, p, f);
    p = 0;
    drive(4'b1110, 7'h7F);
    hold(S, p, f);
    drive(4'b1111, 7'h00);
    hold(20, p, f);
    chk("short_pulses", p, 0);
    chk("short_d0", digit0_segments, 7'h06);
    drive(4'b1110, 7'h7F);
    hold(S + 1, p, f);
    drive(4'b1111, 7'h00);
    hold(20, p, f);
    chk("edge_pulses", p, 1);
    chk("edge_d0", digit0_segments, 7'h7F);

    // Reset at edge 5 of a pending capture
    p = 0; f = 0;
    drive(4'b1110, 7'h06);
    hold(4, p, f);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_zero",
        {digit0_segments, digit1_segments, digit2_segments, digit3_segments, digit_hex,
         hex_valid, capture_valid, capture_idx, frame_done, anode_error}, '0);
    rst_n = 1'b1;
    for (int e = 1; e <= S + 4; e++) begin
      @(negedge clk);
      chk("mid_rst_cv", capture_valid, (e == S + 3) ? 1 : 0);
    end
    chk("mid_rst_d0", digit0_segments, 7'h06);
    chk("mid_rst_err", anode_error, 0);

    // Random traffic against the model
    for (int k = 0; k < 250; k++) begin
      int kind;
      logic [3:0] an;
      logic [6:0] pat;
      kind = $urandom_range(0, 99);
      if (kind < 80) an = ~(4'b0001 << $urandom_range(0, 3));
      else if (kind < 90) an = 4'hF;
      else begin
        an = 4'($urandom);
        while ($countones(~an) < 2) an = 4'($urandom);
      end
      pat = ($urandom_range(0, 1) == 1) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
      if ($urandom_range(0, 99) < 3) begin
        rst_n = 1'b0;
        drive(an, pat);
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst_n = 1'b1;
      end else begin
        drive(an, pat);
      end
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
